xbar_prio_sched: RTL and testbench



---
 rtl/xbar_sched_pkg.sv | 40 ++++
 rtl/xbar_sched_bank.sv | 77 +++++++
 rtl/xbar_prio_sched.sv | 99 +++++++++
 tb/tb_xbar_prio_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_sched_pkg.sv
// Shared definitions for the crossbar priority scheduler.
//  - pick_t / lowest_idx : priority encoder (lowest set bit, plus valid flag).
//  - idx_w / cnt_w       : width helpers used to derive each module's
//                          IdxW / CntW localparams from its own parameters.
// The encoder works on a MaxIn-bit vector, so NumIn may not exceed MaxIn.
package xbar_sched_pkg;

    localparam int MaxIn   = 32;
    localparam int MaxIdxW = 5;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } pick_t;

    // Width of an index into n entries (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach thr inclusive.
    function automatic int cnt_w(input int thr);
        return $clog2(thr + 1);
    endfunction

    // Lowest set bit of vec; valid is 0 when vec is all zeros.
    function automatic pick_t lowest_idx(input logic [MaxIn-1:0] vec);
        pick_t r;
        r = '0;
        // Scan downwards so the last hit written is the lowest index.
        for (int i = MaxIn - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = MaxIdxW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xbar_sched_bank.sv
// Per-bank priority pointer with starvation lock.
// Ports:
//  clk_i, rst_i : clock, synchronous active-high reset
//  en_i         : 0 freezes the pointer and lock
//  sreq_i       : requesters that are starving, requesting, ungranted and
//                 addressing this bank
//  gnt_i        : requesters granted on this bank this cycle
//  rr_o         : registered priority index fed to the crossbar arbiter
//  lock_o       : registered flag, pointer held by a starvation lock
module xbar_sched_bank
    import xbar_sched_pkg::*;
#(
    parameter int NumIn = 4,
    parameter int IdxW  = idx_w(NumIn)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [NumIn-1:0] sreq_i,
    input  logic [NumIn-1:0] gnt_i,
    output logic [IdxW-1:0]  rr_o,
    output logic             lock_o
);

    logic [IdxW-1:0]  rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [MaxIn-1:0] sreq_pad, gnt_pad;
    pick_t            s_pick, g_pick;
    int unsigned      g_idx;

    // NOTE: every signal written in always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sreq_pad              = '0;
        gnt_pad               = '0;
        sreq_pad[NumIn-1:0]   = sreq_i;
        gnt_pad[NumIn-1:0]    = gnt_i;
        s_pick                = lowest_idx(sreq_pad);
        g_pick                = lowest_idx(gnt_pad);
        g_idx                 = int'(g_pick.idx);
        rr_d                  = rr_q;
        lock_d                = lock_q;

        if (en_i) begin
            if (s_pick.valid) begin
                // Keep serving the current lock holder while it still waits;
                // otherwise move to the lowest starving requester.
                lock_d = 1'b1;
                if (!(lock_q && sreq_i[rr_q])) begin
                    rr_d = IdxW'(s_pick.idx);
                end
            end else if (g_pick.valid) begin
                // Explicit wrap so non-power-of-2 NumIn still cycles correctly.
                lock_d = 1'b0;
                rr_d   = (g_idx + 1 == NumIn) ? '0 : IdxW'(g_idx + 1);
            end else begin
                lock_d = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
        end
    end

    assign rr_o   = rr_q;
    assign lock_o = lock_q;

endmodule

// File: rtl/xbar_prio_sched.sv
// Priority scheduler driving the external priority inputs of a TCDM crossbar.
// Observes request, bank address and grant vectors; keeps per-requester wait
// counters and one pointer/lock pair per bank.
// Ports:
//  clk_i, rst_i : clock, synchronous active-high reset
//  en_i         : 1 schedule normally, 0 freeze all state
//  req_i        : [NumIn]        master requests
//  add_i        : [NumIn*AddW]   bank index per master (packed, master 0 lowest)
//  gnt_i        : [NumIn]        master grants from the crossbar
//  rr_o         : [NumOut*IdxW]  registered priority index per bank
//  starve_o     : [NumIn]        requester waited StarveThr cycles
//  lock_o       : [NumOut]       bank pointer held by a starvation lock
module xbar_prio_sched
    import xbar_sched_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter int NumOut    = 4,
    parameter int StarveThr = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [NumIn-1:0]       req_i,
    input  logic [NumIn*(NumOut > 1 ? $clog2(NumOut) : 1)-1:0] add_i,
    input  logic [NumIn-1:0]       gnt_i,
    output logic [NumOut*$clog2(NumIn)-1:0] rr_o,
    output logic [NumIn-1:0]       starve_o,
    output logic [NumOut-1:0]      lock_o
);

    localparam int IdxW = idx_w(NumIn);
    localparam int AddW = idx_w(NumOut);
    localparam int CntW = cnt_w(StarveThr);

    logic [CntW-1:0]  wait_q [NumIn];
    logic [CntW-1:0]  wait_d [NumIn];
    logic [NumIn-1:0] starve;
    logic [NumIn-1:0] bank_sreq [NumOut];
    logic [NumIn-1:0] bank_gnt  [NumOut];

    // Wait counters: count stalled cycles, saturate at StarveThr,
    // clear on grant or when the request drops.
    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            starve[j] = (wait_q[j] == CntW'(StarveThr));
            wait_d[j] = wait_q[j];
            if (en_i) begin
                if (req_i[j] && !gnt_i[j]) begin
                    if (!starve[j]) begin
                        wait_d[j] = wait_q[j] + 1'b1;
                    end
                end else begin
                    wait_d[j] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= '{default: '0};
        end else begin
            wait_q <= wait_d;
        end
    end

    assign starve_o = starve;

    // Route each requester to the bank it addresses. An out-of-range bank
    // index matches no k, so it never touches a pointer.
    always_comb begin
        for (int k = 0; k < NumOut; k++) begin
            bank_sreq[k] = '0;
            bank_gnt[k]  = '0;
            for (int j = 0; j < NumIn; j++) begin
                if (add_i[j*AddW +: AddW] == AddW'(k)) begin
                    bank_sreq[k][j] = starve[j] & req_i[j] & ~gnt_i[j];
                    bank_gnt[k][j]  = gnt_i[j];
                end
            end
        end
    end

    for (genvar k = 0; k < NumOut; k++) begin : g_bank
        xbar_sched_bank #(
            .NumIn (NumIn),
            .IdxW  (IdxW)
        ) u_bank (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i),
            .sreq_i (bank_sreq[k]),
            .gnt_i  (bank_gnt[k]),
            .rr_o   (rr_o[k*IdxW +: IdxW]),
            .lock_o (lock_o[k])
        );
    end

endmodule

// File: tb/tb_xbar_prio_sched.sv
module tb_xbar_prio_sched;

    localparam int NIN  = 4;
    localparam int NOUT = 4;
    localparam int THR  = 4;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] req, gnt;
    logic [7:0] add;
    logic [7:0] rr;
    logic [3:0] starve, lock;

    always #5 clk = ~clk;

    xbar_prio_sched #(
        .NumIn     (NIN),
        .NumOut    (NOUT),
        .StarveThr (THR)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .req_i    (req),
        .add_i    (add),
        .gnt_i    (gnt),
        .rr_o     (rr),
        .starve_o (starve),
        .lock_o   (lock)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Reference state: plain integers, stepped once per rising edge.
    int m_wait [NIN];
    int m_rr   [NOUT];
    bit m_lock [NOUT];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] adds(input int a0, input int a1, input int a2, input int a3);
        return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    endfunction

    function automatic int rr_of(input int k);
        return int'(rr[k*2 +: 2]);
    endfunction

    function automatic int m_starve_vec();
        int v = 0;
        for (int j = 0; j < NIN; j++) if (m_wait[j] == THR) v |= (1 << j);
        return v;
    endfunction

    function automatic int m_lock_vec();
        int v = 0;
        for (int k = 0; k < NOUT; k++) if (m_lock[k]) v |= (1 << k);
        return v;
    endfunction

    // Apply the scheduling rules to the inputs sampled at this edge.
    task automatic model_update();
        int nrr [NOUT];
        bit nlock [NOUT];
        if (rst) begin
            for (int j = 0; j < NIN; j++) m_wait[j] = 0;
            for (int k = 0; k < NOUT; k++) begin m_rr[k] = 0; m_lock[k] = 0; end
            return;
        end
        if (!en) return;
        for (int k = 0; k < NOUT; k++) begin
            int  s_low = -1;
            int  g_low = -1;
            bit  cur_waiting = 0;
            nrr[k]   = m_rr[k];
            nlock[k] = 0;
            for (int j = 0; j < NIN; j++) begin
                if (int'(add[j*2 +: 2]) == k) begin
                    if (m_wait[j] == THR && req[j] && !gnt[j]) begin
                        if (s_low < 0) s_low = j;
                        if (j == m_rr[k]) cur_waiting = 1;
                    end
                    if (gnt[j] && g_low < 0) g_low = j;
                end
            end
            if (s_low >= 0) begin
                nlock[k] = 1;
                if (!(m_lock[k] && cur_waiting)) nrr[k] = s_low;
            end else if (g_low >= 0) begin
                nrr[k] = (g_low + 1) % NIN;
            end
        end
        for (int k = 0; k < NOUT; k++) begin m_rr[k] = nrr[k]; m_lock[k] = nlock[k]; end
        for (int j = 0; j < NIN; j++) begin
            if (req[j] && !gnt[j]) m_wait[j] = (m_wait[j] < THR) ? m_wait[j] + 1 : THR;
            else                   m_wait[j] = 0;
        end
    endtask

    // One cycle: drive inputs, let the edge happen, settle to the falling edge.
    task automatic step(input logic r, input logic e, input logic [3:0] rq,
                        input logic [7:0] ad, input logic [3:0] g);
        rst = r; en = e; req = rq; add = ad; gnt = g;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 4'b0000, adds(0, 0, 0, 0), 4'b0000);
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NOUT; k++) check($sformatf("model rr[%0d]", k), rr_of(k), m_rr[k]);
            check("model starve", int'(starve), m_starve_vec());
            check("model lock", int'(lock), m_lock_vec());
        end
    end

    initial begin
        for (int j = 0; j < NIN; j++) m_wait[j] = 0;
        for (int k = 0; k < NOUT; k++) begin m_rr[k] = 0; m_lock[k] = 0; end

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
        check_en = 1'b1;
        check("reset rr", int'(rr), 0);
        check("reset starve", int'(starve), 0);
        check("reset lock", int'(lock), 0);

        // Round-robin on bank 2.
        step(1'b0, 1'b1, 4'b1111, adds(2, 2, 2, 2), 4'b0001);
        check("rr2 after g0", rr_of(2), 1);
        step(1'b0, 1'b1, 4'b1111, adds(2, 2, 2, 2), 4'b0010);
        check("rr2 after g1", rr_of(2), 2);
        step(1'b0, 1'b1, 4'b1111, adds(2, 2, 2, 2), 4'b0100);
        check("rr2 after g2", rr_of(2), 3);
        step(1'b0, 1'b1, 4'b1111, adds(2, 2, 2, 2), 4'b1000);
        check("rr2 after g3 wrap", rr_of(2), 0);
        check("rr others untouched", int'(rr), 0);
        idle();

        // Single starver on bank 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("starve not yet", int'(starve), 0);
        step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("starve1 at thr", int'(starve), 4'b0010);
        step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("lock rr0", rr_of(0), 1);
        check("lock0 set", int'(lock), 4'b0001);
        step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0010);
        check("grant after lock rr0", rr_of(0), 2);
        check("lock0 cleared", int'(lock), 0);
        idle();

        // Two starvers on bank 1.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1100, adds(0, 0, 1, 1), 4'b0000);
        check("two starve", int'(starve), 4'b1100);
        step(1'b0, 1'b1, 4'b1100, adds(0, 0, 1, 1), 4'b0000);
        check("lock to 2", rr_of(1), 2);
        check("lock1 set", int'(lock), 4'b0010);
        step(1'b0, 1'b1, 4'b1100, adds(0, 0, 1, 1), 4'b0100);
        check("lock moves to 3", rr_of(1), 3);
        check("lock1 kept over grant", int'(lock), 4'b0010);
        step(1'b0, 1'b1, 4'b1000, adds(0, 0, 1, 1), 4'b0000);
        check("lock holds 3", rr_of(1), 3);
        step(1'b0, 1'b1, 4'b1000, adds(0, 0, 1, 1), 4'b1000);
        check("wrap after 3 granted", rr_of(1), 0);
        check("lock1 released", int'(lock), 0);
        idle();

        // Freeze during contention on bank 3.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b0011, adds(3, 3, 0, 0), 4'b0000);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b0011, adds(3, 3, 0, 0), 4'b0000);
        check("freeze no starve", int'(starve), 0);
        check("freeze rr3", rr_of(3), 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b0011, adds(3, 3, 0, 0), 4'b0000);
        check("starve after unfreeze", int'(starve), 4'b0011);
        step(1'b0, 1'b1, 4'b0011, adds(3, 3, 0, 0), 4'b0000);
        check("lock3 set", int'(lock), 4'b1000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0011, adds(3, 3, 0, 0), 4'b0001);
        check("frozen lock3", int'(lock), 4'b1000);
        check("frozen rr3", rr_of(3), 0);
        step(1'b0, 1'b1, 4'b0011, adds(3, 3, 0, 0), 4'b0001);
        check("lock3 to 1", rr_of(3), 1);
        step(1'b0, 1'b1, 4'b0011, adds(3, 3, 0, 0), 4'b0010);
        check("grant1 rr3", rr_of(3), 2);
        check("lock3 released", int'(lock), 0);
        idle();

        // Reset while locked.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("pre-reset lock0", int'(lock), 4'b0001);
        step(1'b1, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("mid-lock reset rr", int'(rr), 0);
        check("mid-lock reset lock", int'(lock), 0);
        check("mid-lock reset starve", int'(starve), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("starve restarts", int'(starve), 0);
        step(1'b0, 1'b1, 4'b0010, adds(0, 0, 0, 0), 4'b0000);
        check("starve again", int'(starve), 4'b0010);
        idle();

        // Random traffic, checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rq;
            rq = 4'($urandom);
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0), rq,
                 8'($urandom), rq & 4'($urandom) & 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
